// File: rtl/prog_loader_if.sv
// Word stream handshake between an image source and the boot loader.
interface prog_loader_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Boot loader: streams an image into memory, optionally verifies it by
// read-back checksum, then hands the memory port to the control unit.
module prog_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int VERIFY     = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  prog_loader_if.slave          s_in,
  input  logic [ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [DATA_WIDTH-1:0] ctrl_to_mem,
  input  logic                  ctrl_mem_clock,
  input  logic                  ctrl_mem_write,
  output logic [DATA_WIDTH-1:0] ctrl_from_mem,
  output logic                  mem_clock,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_to,
  input  logic [DATA_WIDTH-1:0] mem_from,
  output logic                  cpu_run,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   load_count
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STROBE, S_VERIFY, S_CHECK, S_RUN, S_ERROR
  } state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_to;
  logic                  r_write;
  logic                  r_last;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_ptr;
  logic [DATA_WIDTH-1:0] r_sum;
  logic [DATA_WIDTH-1:0] r_vsum;

  logic                  w_accept;
  logic                  w_run;
  logic                  w_restart;
  logic [CW-1:0]         w_count_inc;
  logic [CW-1:0]         w_ptr_inc;
  logic                  w_full;

  assign w_accept    = (r_state == S_LOAD) && s_in.in_valid;
  assign w_run       = (r_state == S_RUN);
  assign w_restart   = start && ((r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERROR));
  assign w_count_inc = r_count + 1'b1;
  assign w_ptr_inc   = r_ptr + 1'b1;
  assign w_full      = (w_count_inc == CW'(DEPTH));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD:   if (w_accept) w_next = S_STROBE;
      S_STROBE: begin
        if (r_last || w_full) w_next = (VERIFY != 0) ? S_VERIFY : S_RUN;
        else                  w_next = S_LOAD;
      end
      S_VERIFY: if (w_ptr_inc == r_count) w_next = S_CHECK;
      S_CHECK:  w_next = (r_vsum == r_sum) ? S_RUN : S_ERROR;
      S_RUN:    if (start) w_next = S_LOAD;
      S_ERROR:  if (start) w_next = S_LOAD;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_to    <= '0;
      r_write <= 1'b0;
      r_last  <= 1'b0;
      r_count <= '0;
      r_ptr   <= '0;
      r_sum   <= '0;
      r_vsum  <= '0;
    end else begin
      r_state <= w_next;
      if (w_restart) begin
        r_count <= '0;
        r_sum   <= '0;
        r_last  <= 1'b0;
      end
      if (w_accept) begin
        r_addr  <= r_count[ADDR_WIDTH-1:0];
        r_to    <= s_in.in_data;
        r_write <= 1'b1;
        r_sum   <= r_sum + s_in.in_data;
        r_last  <= s_in.in_last;
      end
      if (r_state == S_STROBE) begin
        r_count <= w_count_inc;
        r_write <= 1'b0;
        r_ptr   <= '0;
        r_vsum  <= '0;
      end
      if (r_state == S_VERIFY) begin
        r_vsum <= r_vsum + mem_from;
        r_ptr  <= w_ptr_inc;
      end
    end
  end

  // In RUN the memory port is a pure pass-through of the ctrl inputs.
  assign s_in.in_ready = (r_state == S_LOAD);
  assign mem_clock     = w_run ? ctrl_mem_clock : (r_state == S_STROBE);
  assign mem_write     = w_run ? ctrl_mem_write : r_write;
  assign mem_addr      = w_run ? ctrl_addr
                       : (r_state == S_VERIFY) ? r_ptr[ADDR_WIDTH-1:0] : r_addr;
  assign mem_to        = w_run ? ctrl_to_mem : r_to;
  assign ctrl_from_mem = mem_from;
  assign cpu_run       = w_run;
  assign done          = w_run;
  assign error         = (r_state == S_ERROR);
  assign load_count    = r_count;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: one verifying instance (A) and one
// non-verifying instance (B), each with its own behavioural memory.
module tb_prog_loader;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int nchecks = 0;
  int nerr    = 0;

  prog_loader_if #(.DATA_WIDTH(8)) ifa ();
  prog_loader_if #(.DATA_WIDTH(8)) ifb ();

  logic       startA = 1'b0, startB = 1'b0;
  logic [7:0] ctrl_addr = '0, ctrl_to_mem = '0;
  logic       ctrl_mem_clock = 1'b0, ctrl_mem_write = 1'b0;

  logic [7:0] ctrl_fromA, mem_addrA, mem_toA, mem_fromA;
  logic       mem_clockA, mem_writeA, cpu_runA, doneA, errorA;
  logic [8:0] load_countA;
  logic [7:0] ctrl_fromB, mem_addrB, mem_toB, mem_fromB;
  logic       mem_clockB, mem_writeB, cpu_runB, doneB, errorB;
  logic [8:0] load_countB;

  logic [7:0] memA [256];
  logic [7:0] memB [256];
  bit         faultA = 1'b0;
  int         wcntB  = 0;

  prog_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .VERIFY(1)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .start(startA), .s_in(ifa),
    .ctrl_addr(ctrl_addr), .ctrl_to_mem(ctrl_to_mem),
    .ctrl_mem_clock(ctrl_mem_clock), .ctrl_mem_write(ctrl_mem_write),
    .ctrl_from_mem(ctrl_fromA), .mem_clock(mem_clockA), .mem_write(mem_writeA),
    .mem_addr(mem_addrA), .mem_to(mem_toA), .mem_from(mem_fromA),
    .cpu_run(cpu_runA), .done(doneA), .error(errorA), .load_count(load_countA));

  prog_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .VERIFY(0)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(startB), .s_in(ifb),
    .ctrl_addr(8'h00), .ctrl_to_mem(8'h00),
    .ctrl_mem_clock(1'b0), .ctrl_mem_write(1'b0),
    .ctrl_from_mem(ctrl_fromB), .mem_clock(mem_clockB), .mem_write(mem_writeB),
    .mem_addr(mem_addrB), .mem_to(mem_toB), .mem_from(mem_fromB),
    .cpu_run(cpu_runB), .done(doneB), .error(errorB), .load_count(load_countB));

  assign mem_fromA = (faultA && mem_addrA == 8'd2) ? 8'h32 : memA[mem_addrA];
  assign mem_fromB = memB[mem_addrB];

  always @(posedge mem_clockA) begin
    #1;
    if (mem_writeA) memA[mem_addrA] = mem_toA;
  end

  always @(posedge mem_clockB) begin
    #1;
    if (mem_writeB) begin
      memB[mem_addrB] = mem_toB;
      wcntB++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a word and return just after the edge that accepts it.
  task automatic send(input bit b, input logic [7:0] d, input logic l);
    int n = 0;
    if (b) begin ifb.in_valid = 1'b1; ifb.in_data = d; ifb.in_last = l; end
    else   begin ifa.in_valid = 1'b1; ifa.in_data = d; ifa.in_last = l; end
    while (!(b ? ifb.in_ready : ifa.in_ready) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'(n), 32'd0);
    tick();
    if (b) ifb.in_valid = 1'b0;
    else   ifa.in_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit b);
    if (b) startB = 1'b1; else startA = 1'b1;
    tick();
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic wait_settle_a(input int limit);
    int n = 0;
    while (!cpu_runA && !errorA && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) chk("settle_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin memA[i] = '0; memB[i] = '0; end
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_last = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_last = 1'b0;

    #2;
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("rst_mem_clock", 32'(mem_clockA), 32'd0);
    chk("rst_mem_write", 32'(mem_writeA), 32'd0);
    chk("rst_cpu_run", 32'(cpu_runA), 32'd0);
    chk("rst_error", 32'(errorA), 32'd0);
    chk("rst_load_count", 32'(load_countA), 32'd0);
    chk("rst_mem_addr", 32'(mem_addrA), 32'd0);
    #10 reset_n = 1'b1;
    tick();

    // start with in_valid in IDLE: no word accepted that cycle
    ifa.in_valid = 1'b1; ifa.in_data = 8'h11; startA = 1'b1;
    #1;
    chk("idle_in_ready", 32'(ifa.in_ready), 32'd0);
    tick();
    startA = 1'b0;
    chk("idle_no_write", 32'(mem_writeA), 32'd0);
    chk("load_in_ready", 32'(ifa.in_ready), 32'd1);
    send(1'b0, 8'h11, 1'b0);
    send(1'b0, 8'h22, 1'b0);
    send(1'b0, 8'h33, 1'b0);
    send(1'b0, 8'h44, 1'b1);
    repeat (5) tick();
    chk("t1_check_cpu_run", 32'(cpu_runA), 32'd0);
    tick();
    chk("t1_cpu_run", 32'(cpu_runA), 32'd1);
    chk("t1_done", 32'(doneA), 32'd1);
    chk("t1_error", 32'(errorA), 32'd0);
    chk("t1_load_count", 32'(load_countA), 32'd4);
    chk("t1_mem", {memA[0], memA[1], memA[2], memA[3]}, 32'h11223344);

    // corrupted readback -> ERROR, then a clean reload runs
    faultA = 1'b1;
    pulse_start(1'b0);
    chk("t2_restart_clears", 32'({cpu_runA, load_countA}), 32'd0);
    send(1'b0, 8'h11, 1'b0);
    send(1'b0, 8'h22, 1'b0);
    send(1'b0, 8'h33, 1'b0);
    send(1'b0, 8'h44, 1'b1);
    repeat (6) tick();
    chk("t2_error", 32'(errorA), 32'd1);
    chk("t2_cpu_run", 32'(cpu_runA), 32'd0);
    chk("t2_mem_idle", 32'({mem_clockA, mem_writeA}), 32'd0);
    faultA = 1'b0;
    pulse_start(1'b0);
    chk("t2_err_cleared", 32'(errorA), 32'd0);
    send(1'b0, 8'h11, 1'b0);
    send(1'b0, 8'h22, 1'b0);
    send(1'b0, 8'h33, 1'b0);
    send(1'b0, 8'h44, 1'b1);
    repeat (6) tick();
    chk("t2_reload_run", 32'({cpu_runA, errorA}), 32'h2);

    // full image of 256 words without in_last
    pulse_start(1'b0);
    for (int i = 0; i < 256; i++) send(1'b0, 8'(i), 1'b0);
    ifa.in_valid = 1'b1; ifa.in_data = 8'hEE;
    tick();
    chk("t3_in_ready_full", 32'(ifa.in_ready), 32'd0);
    chk("t3_load_count", 32'(load_countA), 32'd256);
    wait_settle_a(300);
    chk("t3_run", 32'({cpu_runA, errorA}), 32'h2);
    chk("t3_mem", {memA[0], memA[128], memA[255], 8'h00}, 32'h0080FF00);
    ifa.in_valid = 1'b0;

    // VERIFY=0 instance: stalled source holds LOAD without writes
    pulse_start(1'b1);
    send(1'b1, 8'hA1, 1'b0);
    send(1'b1, 8'hA2, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold", 32'({ifb.in_ready, mem_clockB, load_countB}), 32'h402);
      tick();
    end
    send(1'b1, 8'hA3, 1'b1);
    chk("t4_strobe", 32'({mem_clockB, cpu_runB}), 32'h2);
    tick();
    chk("t4_run", 32'({cpu_runB, doneB}), 32'h3);
    chk("t4_writes", 32'(wcntB), 32'd3);
    chk("t4_mem", {memB[0], memB[1], memB[2], 8'h00}, 32'hA1A2A300);

    // asynchronous reset during the strobe of word 3
    pulse_start(1'b0);
    send(1'b0, 8'h51, 1'b0);
    send(1'b0, 8'h52, 1'b0);
    send(1'b0, 8'h53, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_outs", 32'({ifa.in_ready, mem_clockA, mem_writeA, cpu_runA, doneA, errorA}), 32'd0);
    chk("t5_rst_vals", {7'd0, load_countA, mem_addrA, mem_toA}, 32'd0);
    chk("t5_retained", 32'({memA[0], memA[1]}), 32'h5152);
    #5 reset_n = 1'b1;
    tick();
    pulse_start(1'b0);
    send(1'b0, 8'h61, 1'b0);
    send(1'b0, 8'h62, 1'b0);
    send(1'b0, 8'h63, 1'b1);
    wait_settle_a(20);
    chk("t5_restart_run", 32'({cpu_runA, errorA, load_countA}), 32'h403);

    // ctrl owns the memory in RUN
    ctrl_addr = 8'h05; ctrl_to_mem = 8'h7E; ctrl_mem_write = 1'b1;
    #1;
    chk("t6_pass", 32'({mem_addrA, mem_toA, mem_writeA}), 32'h0A_FD);
    ctrl_mem_clock = 1'b1;
    #3;
    ctrl_mem_clock = 1'b0;
    ctrl_mem_write = 1'b0;
    #1;
    chk("t6_mem5", 32'(memA[5]), 32'h7E);
    chk("t6_from_mem", 32'(ctrl_fromA), 32'h7E);
    ctrl_addr = 8'h01;
    #1;
    chk("t6_from_mem_a1", 32'(ctrl_fromA), 32'h62);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Sequential boot loader that streams a program image into the unified memory, then hands the memory port to the control unit.
- Sits between a byte/word source (bench file reader or external link), the mem block and ctrl.
- Replaces ad-hoc port switching with a registered state machine and word handshake.
- Adds optional read-back checksum verification before releasing the CPU.

Parameters:
DATA_WIDTH, 8, memory word and stream word width
ADDR_WIDTH, 8, memory address width; DEPTH = 2**ADDR_WIDTH words
VERIFY, 1, 1 = read back and checksum image before run; 0 = run straight after load

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a new load (honoured in IDLE, RUN, ERROR)
in_valid  in  1  source has a word
in_data  in  DATA_WIDTH  stream word
in_last  in  1  qualifies final word of image
in_ready  out  1  loader accepts word this cycle
ctrl_addr  in  ADDR_WIDTH  ctrl memory address
ctrl_to_mem  in  DATA_WIDTH  ctrl write data
ctrl_mem_clock  in  1  ctrl memory strobe
ctrl_mem_write  in  1  ctrl write enable
ctrl_from_mem  out  DATA_WIDTH  read data to ctrl (= mem_from, always)
mem_clock  out  1  memory strobe; mem writes on its rising edge when mem_write=1
mem_write  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_to  out  DATA_WIDTH  memory write data
mem_from  in  DATA_WIDTH  memory combinational read data
cpu_run  out  1  level; high only in RUN; parent gates ctrl clock with it
done  out  1  high in RUN
error  out  1  high in ERROR
load_count  out  ADDR_WIDTH+1  words written by last/current load

Behaviour:
- Reset (async, reset_n=0): state IDLE; in_ready, mem_clock, mem_write, cpu_run, done, error = 0; mem_addr, mem_to, load_count, checksum, verify pointer = 0. Mid-operation reset aborts immediately; already-written words are left in memory.
- States: IDLE, LOAD, STROBE, VERIFY, CHECK, RUN, ERROR.
- IDLE: in_ready=0. start -> LOAD, load_count=0, checksum=0.
- LOAD: in_ready=1, mem_clock=0. On in_valid&&in_ready: mem_addr<=load_count, mem_to<=in_data, mem_write<=1, checksum<=checksum+in_data (mod 2**DATA_WIDTH), latch in_last -> STROBE. No valid: hold.
- STROBE: in_ready=0, mem_clock=1 for exactly one cycle (write lands); load_count++. Next: if latched last or load_count (after increment) == DEPTH -> VERIFY (VERIFY=1) else RUN; otherwise -> LOAD. mem_write cleared on leaving STROBE.
- Throughput: one word per 2 clocks. Full: at DEPTH words the load ends even without in_last; no further words accepted (in_ready stays 0).
- VERIFY: mem_write=0, mem_clock=0, mem_addr=pointer (0..load_count-1), one word per cycle; accumulate readback sum from mem_from. After last address -> CHECK.
- CHECK (1 cycle): sums equal -> RUN, else ERROR.
- RUN: loader releases memory: mem_addr/mem_to/mem_clock/mem_write combinationally follow ctrl_* inputs; cpu_run=done=1.
- ERROR: error=1, cpu_run=0, memory outputs idle (clock/write 0).
- start in RUN or ERROR -> LOAD (fresh load, flags cleared same edge). start in LOAD/STROBE/VERIFY/CHECK ignored.
- start and in_valid in same IDLE cycle: only start acts; word not accepted (in_ready=0).
- Outside RUN, ctrl_* inputs are ignored.

Test Plan:
- Reset, start, stream 0x11,0x22,0x33,0x44 (last on 0x44), VERIFY=1 -> mem[0..3] match, load_count=4, checksum 0xAA matches, cpu_run rises 8 load + 4 verify + 1 check cycles after first accept, done=1, error=0.
- Same stream with bench memory model forcing mem[2] readback 0x32 -> CHECK mismatch, error=1, cpu_run stays 0; then start and reload with model fixed -> RUN.
- Stream of 256 words 0x00..0xFF with no in_last, ADDR_WIDTH=8 -> load ends at 256, in_ready=0 thereafter, load_count=256, sum 0x80 verified, RUN.
- in_valid toggled off for 5 cycles mid-image, VERIFY=0 -> loader holds in LOAD, no spurious writes, RUN immediately after STROBE of last word.
- reset_n pulsed low during STROBE of word 3 -> all outputs at reset values same cycle; mem[0..1] retained; restart load succeeds.
- In RUN, ctrl drives addr 0x05, data 0x7E, write=1, strobe pulse -> mem[5]=0x7E; ctrl_from_mem follows mem_from.
